instr_encoder: RTL and testbench

Sequential LEGv8 instruction encoder: the encode side of the CPU's instruction decode path. It accepts one symbolic instruction per handshake (op select, register numbers, immediate) and packs it into the 32-bit machine word the control unit decodes. Each encoded word is written to the instruction-memory load port at an auto-incrementing address. Bench and boot logic use it to build programs in instruction memory.

---
 rtl/instr_encoder.sv | 139 +++++++++++++
 tb/tb_instr_encoder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: packs one symbolic LEGv8 instruction per handshake into its
// 32-bit machine word and presents it on the instruction-memory load port at an
// auto-incrementing byte address.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   restart               synchronous: wr_addr back to BASE_ADDR, err_count cleared
//   in_valid / in_ready   symbolic instruction handshake (op, rd, rn, rm, imm)
//   wr_valid / wr_ready   memory write handshake (wr_addr, wr_data)
//   err                   one-cycle pulse after an illegal instruction is dropped
//   err_count             saturating count of dropped instructions
module instr_encoder #(
  parameter int unsigned           ADDR_W    = 64,
  parameter logic [ADDR_W-1:0]     BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [4:0]        rd,
  input  logic [4:0]        rn,
  input  logic [4:0]        rm,
  input  logic [25:0]       imm,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              err,
  output logic [7:0]        err_count
);

  typedef enum logic [3:0] {
    OP_ADDI = 4'd0,
    OP_ADDS = 4'd1,
    OP_B    = 4'd2,
    OP_BLT  = 4'd3,
    OP_CBZ  = 4'd4,
    OP_LDUR = 4'd5,
    OP_LSL  = 4'd6,
    OP_LSR  = 4'd7,
    OP_MUL  = 4'd8,
    OP_STUR = 4'd9,
    OP_SUBS = 4'd10
  } op_e;

  logic [31:0] enc;
  logic        legal;
  logic        accept;
  logic        drain;
  // A restart that arrives while a word is stalled must not move that word's
  // address, so it is remembered and applied when the word drains.
  logic        restart_pend;

  always_comb begin
    enc   = '0;
    legal = 1'b1;
    case (op_e'(op))
      OP_ADDI: begin
        enc   = {10'b1001000100, imm[11:0], rn, rd};
        legal = (imm[25:12] == '0);
      end
      OP_ADDS: enc = {11'b10101011000, rm, 6'b000000, rn, rd};
      OP_SUBS: enc = {11'b11101011000, rm, 6'b000000, rn, rd};
      OP_MUL:  enc = {11'b10011011000, rm, 6'b011111, rn, rd};
      OP_LSL: begin
        enc   = {11'b11010011011, 5'b00000, imm[5:0], rn, rd};
        legal = (imm[25:6] == '0);
      end
      OP_LSR: begin
        enc   = {11'b11010011010, 5'b00000, imm[5:0], rn, rd};
        legal = (imm[25:6] == '0);
      end
      // Signed offsets are legal when all upper bits replicate the sign bit.
      OP_LDUR: begin
        enc   = {11'b11111000010, imm[8:0], 2'b00, rn, rd};
        legal = (&imm[25:8]) || (imm[25:8] == '0);
      end
      OP_STUR: begin
        enc   = {11'b11111000000, imm[8:0], 2'b00, rn, rd};
        legal = (&imm[25:8]) || (imm[25:8] == '0);
      end
      OP_B:    enc = {6'b000101, imm[25:0]};
      OP_CBZ: begin
        enc   = {8'b10110100, imm[18:0], rd};
        legal = (&imm[25:18]) || (imm[25:18] == '0);
      end
      OP_BLT: begin
        enc   = {8'b01010100, imm[18:0], 5'b01011};
        legal = (&imm[25:18]) || (imm[25:18] == '0);
      end
      default: legal = 1'b0;
    endcase
  end

  assign in_ready = !wr_valid || wr_ready;
  assign accept   = in_valid && in_ready;
  assign drain    = wr_valid && wr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_valid     <= 1'b0;
      wr_data      <= '0;
      wr_addr      <= BASE_ADDR;
      err          <= 1'b0;
      err_count    <= '0;
      restart_pend <= 1'b0;
    end else begin
      err <= accept && !legal;

      if (accept && legal) begin
        wr_valid <= 1'b1;
        wr_data  <= enc;
      end else if (drain) begin
        wr_valid <= 1'b0;
      end

      if (restart) begin
        if (drain || !wr_valid) begin
          wr_addr      <= BASE_ADDR;
          restart_pend <= 1'b0;
        end else begin
          restart_pend <= 1'b1;
        end
      end else if (drain) begin
        wr_addr      <= restart_pend ? BASE_ADDR : wr_addr + ADDR_W'(4);
        restart_pend <= 1'b0;
      end

      if (restart) begin
        err_count <= '0;
      end else if (accept && !legal && (err_count != '1)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed plus randomized checks of instr_encoder against a
// behavioural model (arithmetic encoder, word queue, address/error counters).
module tb_instr_encoder;

  localparam logic [63:0] BASE = 64'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        restart;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [4:0]  rd;
  logic [4:0]  rn;
  logic [4:0]  rm;
  logic [25:0] imm;
  logic        wr_valid;
  logic        wr_ready;
  logic [63:0] wr_addr;
  logic [31:0] wr_data;
  logic        err;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(64), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .restart(restart),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rd(rd), .rn(rn), .rm(rm), .imm(imm),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .err(err), .err_count(err_count)
  );

  int unsigned       n_chk  = 0;
  int unsigned       n_fail = 0;
  logic [31:0]       q[$];
  longint unsigned   m_addr;
  bit                m_pend;
  int                m_cnt;
  bit                m_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned rfmt(input longint unsigned opc, input longint unsigned m,
                                           input longint unsigned sh, input longint unsigned n,
                                           input longint unsigned d);
    return opc * 2097152 + m * 65536 + sh * 1024 + n * 32 + d;
  endfunction

  // Returns {legal, word} from the instruction-set rules.
  function automatic logic [32:0] ref_enc(input longint unsigned o, input longint unsigned d,
                                          input longint unsigned n, input longint unsigned m,
                                          input longint unsigned im);
    longint          sv;
    longint unsigned w;
    bit              ok;
    sv = (im >= 64'd33554432) ? longint'(im) - 64'sd67108864 : longint'(im);
    w  = 0;
    ok = 1'b1;
    case (o)
      0: begin ok = (im < 4096); w = 64'h244 * 4194304 + (im % 4096) * 1024 + n * 32 + d; end
      1: w = rfmt(64'h558, m, 0, n, d);
      2: w = 64'd5 * 67108864 + im;
      3: begin
        ok = (sv >= -262144) && (sv < 262144);
        w  = 64'h54 * 16777216 + longint'(((sv % 524288) + 524288) % 524288) * 32 + 11;
      end
      4: begin
        ok = (sv >= -262144) && (sv < 262144);
        w  = 64'hB4 * 16777216 + longint'(((sv % 524288) + 524288) % 524288) * 32 + d;
      end
      5: begin
        ok = (sv >= -256) && (sv < 256);
        w  = 64'h7C2 * 2097152 + longint'(((sv % 512) + 512) % 512) * 4096 + n * 32 + d;
      end
      6: begin ok = (im < 64); w = rfmt(64'h69B, 0, im % 64, n, d); end
      7: begin ok = (im < 64); w = rfmt(64'h69A, 0, im % 64, n, d); end
      8: w = rfmt(64'h4D8, m, 31, n, d);
      9: begin
        ok = (sv >= -256) && (sv < 256);
        w  = 64'h7C0 * 2097152 + longint'(((sv % 512) + 512) % 512) * 4096 + n * 32 + d;
      end
      10: w = rfmt(64'h758, m, 0, n, d);
      default: ok = 1'b0;
    endcase
    return {ok, w[31:0]};
  endfunction

  task automatic model_reset();
    q.delete();
    m_addr = BASE;
    m_pend = 1'b0;
    m_cnt  = 0;
    m_err  = 1'b0;
  endtask

  // One clock: mid-cycle compare against the model, then advance model and DUT.
  task automatic cycle();
    logic [32:0] e;
    bit          has;
    bit          drn;
    bit          fire;
    #4;
    has = (q.size() != 0);
    chk("in_ready", in_ready, (!has || wr_ready));
    chk("wr_valid", wr_valid, has);
    if (has) begin
      chk("wr_data", wr_data, q[0]);
      chk("wr_addr", wr_addr, m_addr);
    end
    chk("err", err, m_err);
    chk("err_count", err_count, m_cnt);
    drn  = has && wr_ready;
    fire = in_valid && (!has || wr_ready);
    e    = ref_enc(op, rd, rn, rm, imm);
    if (drn) void'(q.pop_front());
    if (restart) begin
      if (drn || !has) begin m_addr = BASE; m_pend = 1'b0; end
      else m_pend = 1'b1;
    end else if (drn) begin
      m_addr = m_pend ? BASE : m_addr + 4;
      m_pend = 1'b0;
    end
    m_err = fire && !e[32];
    if (fire && e[32]) q.push_back(e[31:0]);
    if (restart) m_cnt = 0;
    else if (fire && !e[32] && m_cnt < 255) m_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int o, input int d, input int n, input int m, input longint unsigned im);
    in_valid = 1'b1;
    op  = 4'(o);
    rd  = 5'(d);
    rn  = 5'(n);
    rm  = 5'(m);
    imm = 26'(im);
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic lit(input string tag, input logic [31:0] w, input logic [63:0] a);
    chk(tag, wr_data, w);
    chk({tag, "_addr"}, wr_addr, a);
  endtask

  longint bnd[12] = '{255, 256, -256, -257, 4095, 4096, 63, 64,
                      262143, 262144, -262144, -262145};

  initial begin
    rst_n = 1'b0; restart = 1'b0; in_valid = 1'b0; wr_ready = 1'b1;
    op = '0; rd = '0; rn = '0; rm = '0; imm = '0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_wr_addr", wr_addr, BASE);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_err", err, 0);
    chk("rst_err_count", err_count, 0);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;

    // Basic encodings, streaming with wr_ready high.
    put(0, 1, 2, 0, 5);                 lit("addi", 32'h91001441, 0);
    put(1, 3, 1, 2, 0);                 lit("adds", 32'hAB020023, 4);
    put(10, 3, 1, 2, 0);                lit("subs", 32'hEB020023, 8);
    put(8, 1, 2, 3, 0);                 lit("mul",  32'h9B037C41, 12);
    put(5, 4, 5, 0, 64'd67108856);      lit("ldur", 32'hF85F80A4, 16);
    put(6, 1, 2, 0, 4);                 lit("lsl",  32'hD3601041, 20);
    put(2, 0, 0, 0, 64'd67108863);      lit("b",    32'h17FFFFFF, 24);
    put(3, 9, 0, 0, 3);                 lit("blt",  32'h5400006B, 28);
    put(4, 7, 0, 0, 2);                 lit("cbz",  32'hB4000047, 32);
    cycle();

    // Back-pressure: one word stalls for 3 cycles with the next input waiting.
    wr_ready = 1'b0;
    put(7, 5, 6, 0, 3);
    in_valid = 1'b1; op = 4'd1; rd = 5'd9; rn = 5'd10; rm = 5'd11; imm = '0;
    for (int i = 0; i < 3; i++) cycle();
    wr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd = 5'(20 + i);
      cycle();
    end
    in_valid = 1'b0;
    cycle();

    // Illegal inputs are consumed but produce no word.
    put(12, 1, 1, 1, 0);
    chk("ill_err", err, 1);
    chk("ill_cnt1", err_count, 1);
    chk("ill_nowrite", wr_valid, 0);
    put(0, 1, 1, 0, 4096);
    chk("ill_cnt2", err_count, 2);
    put(0, 2, 2, 0, 1);
    lit("after_ill", 32'h91000442, 52);
    cycle();

    for (int i = 0; i < 300; i++) put(15, i % 32, 0, 0, 0);
    cycle();
    chk("sat_cnt", err_count, 255);

    // restart after 5 writes.
    for (int i = 0; i < 5; i++) put(0, i, i + 1, 0, i * 7);
    cycle();
    restart = 1'b1;
    cycle();
    restart = 1'b0;
    chk("restart_cnt", err_count, 0);
    put(0, 1, 2, 0, 5);
    lit("restart_word", 32'h91001441, BASE);

    // restart in the same cycle a write completes.
    put(1, 1, 1, 1, 0);
    restart = 1'b1;
    cycle();
    restart = 1'b0;
    put(8, 1, 2, 3, 0);
    lit("restart_drain", 32'h9B037C41, BASE);
    cycle();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom % 4) != 0;
      wr_ready = ($urandom % 4) != 0;
      restart  = ($urandom % 40) == 0;
      op = (($urandom % 8) != 0) ? 4'($urandom_range(0, 10)) : 4'($urandom);
      rd = 5'($urandom); rn = 5'($urandom); rm = 5'($urandom);
      case ($urandom % 4)
        0: imm = 26'($urandom);
        1: imm = 26'($urandom_range(0, 300));
        2: imm = 26'(-longint'($urandom_range(1, 300)));
        default: imm = 26'(bnd[$urandom % 12]);
      endcase
      cycle();
    end
    in_valid = 1'b0; restart = 1'b0; wr_ready = 1'b1;
    cycle();

    // Asynchronous reset while a word is pending.
    put(12, 0, 0, 0, 0);
    wr_ready = 1'b0;
    put(1, 1, 2, 3, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_wr_valid", wr_valid, 0);
    chk("arst_wr_addr", wr_addr, BASE);
    chk("arst_err_count", err_count, 0);
    #1;
    rst_n = 1'b1;
    wr_ready = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    chk("arst_in_ready", in_ready, 1);
    put(0, 1, 2, 0, 5);
    lit("arst_word", 32'h91001441, BASE);
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
